// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_SUB_WIDTH = 8;

endpackage

// File: rtl/fullsubtractor.sv
// Combinational one-bit full subtractor: diff = a - b - bin, with borrow-out.
// Serves as the per-bit cell of the serial subtractor.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin, LSB first, one bit per clock.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a level sampled every edge; it is accepted only when
  // the FSM is in IDLE or DONE and silently dropped while SHIFT is running.
  // done is a single-cycle pulse; diff/bout (and ovf) are valid with it and
  // hold until the next accepted start.
  state_t           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_d;
  logic w_bn;

  fullsubtractor u_cell (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_bn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_ra   <= {1'b0, r_ra[WIDTH-1:1]};
          r_rb   <= {1'b0, r_rb[WIDTH-1:1]};
          r_br   <= w_bn;
          r_cnt  <= r_cnt + 1'b1;
          // The MSB is processed on this cycle: publish the final borrow.
          if (r_cnt == LAST) begin
            r_bout  <= w_bn;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= r_br ^ w_bn;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign dbg_state = r_state;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8) with hand-computed vectors.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  state_t       dbg_state;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present operands with start for one edge (the accepting edge)
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // wait for done with a bounded cycle budget; lat counts edges waited
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // scoreboard: compare the done-cycle result with the oldest expectation
  task automatic score(input string tag, input logic exp_ovf);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
      check({tag, "_bout"}, 32'(bout), 32'(e[W]));
    end
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf_x"}, 32'd0, 32'd1);
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ed, input logic eb,
                        input logic eo);
    int lat;
    exp_q.push_back({eb, ed});
    start_op(ta, tb, tbin);
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    score(tag, eo);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int lat;
    int lat2;
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b1;

    // reset held with start asserted
    tick();
    check("rst_state_c1", 32'(dbg_state), 32'(IDLE));
    tick();
    check("rst_state_c2", 32'(dbg_state), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // basic and underflow vectors
    run_op("basic", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
    run_op("under", 8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, 1'b0);
    run_op("zero_bin", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulsed during SHIFT cycle 3 is dropped
    exp_q.push_back({1'b0, 8'd150});
    start_op(8'd200, 8'd50, 1'b0);
    tick();
    tick();
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore", lat);
    check("ignore_latency", 32'(lat + 3), 32'(W));
    score("ignore", 1'b0);
    tick();
    tick();
    check("ignore_no_second_busy", 32'(busy), 32'd0);
    check("ignore_no_second_done", 32'(done), 32'd0);
    check("ignore_state", 32'(dbg_state), 32'(IDLE));

    // back-to-back: start held high through the done cycle
    exp_q.push_back({1'b0, 8'd30});
    exp_q.push_back({1'b0, 8'd5});
    a     = 8'd50;
    b     = 8'd20;
    bin   = 1'b0;
    start = 1'b1;
    tick();
    a = 8'd9;
    b = 8'd4;
    wait_done("b2b_first", lat);
    check("b2b_first_latency", 32'(lat), 32'(W));
    score("b2b_first", 1'b0);
    tick();
    start = 1'b0;
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_done", 32'(done), 32'd0);
    check("b2b_restart_state", 32'(dbg_state), 32'(SHIFT));
    wait_done("b2b_second", lat2);
    check("b2b_period", 32'(lat2 + 1), 32'(W + 1));
    score("b2b_second", 1'b0);
    tick();

    // reset asserted during SHIFT cycle 4
    start_op(8'd77, 8'd11, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done === 1'b1) lat++;
    end
    check("midrst_no_done_pulse", 32'(lat), 32'd0);
    run_op("after_rst", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);

    // signed overflow boundary vectors
    run_op("ovf_set", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_clr", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
